// File: rtl/noc_packet_encoder_if.sv
// noc_packet_encoder_if: command and packet channels of the NoC packet encoder.
//
// Both channels use the same handshake: a transfer happens on the rising clock
// edge where valid and ready are both high. The sender holds valid and its
// payload stable until that edge; ready may come and go freely, and valid
// never waits for ready.
//
// Modports:
//   slave  - the encoder: consumes commands, produces packets.
//   master - the environment: produces commands, consumes packets.
interface noc_packet_encoder_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int OP_WIDTH   = 2,
    parameter int FILTER_W   = 24,
    parameter int SPIKE_W    = 5,
    parameter int PKT_W      = 39
) ();
    // Command channel (memory controller / PE -> encoder)
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [OP_WIDTH-1:0]   cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_dest;
    logic [FILTER_W-1:0]   cmd_filter;
    logic [SPIKE_W-1:0]    cmd_spike;

    // Packet channel (encoder -> NoC router injection port)
    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [PKT_W-1:0]      pkt_data;

    modport slave (
        input  cmd_valid, cmd_op, cmd_dest, cmd_filter, cmd_spike, pkt_ready,
        output cmd_ready, pkt_valid, pkt_data
    );

    modport master (
        output cmd_valid, cmd_op, cmd_dest, cmd_filter, cmd_spike, pkt_ready,
        input  cmd_ready, pkt_valid, pkt_data
    );
endinterface

// File: rtl/noc_packet_encoder.sv
// noc_packet_encoder: packs frame-level commands into NoC packets and queues
// them in a small FIFO for the router injection port.
//
// Packet layout (LSB first): dest | src | op | payload, where the payload is
// {spike, filter} for op 0, {0, spike} for op 1 and {0, filter} for op 2.
// Op 3 is accepted, dropped and flagged in the sticky err_illegal_op.
//
// Optional feature, macro SPIKE_ZERO_SUPPRESS_EN: op 1 commands carrying an
// all-zero spike frame are accepted but dropped, and counted on the extra
// suppress_count output.
module noc_packet_encoder #(
    parameter int ADDR_WIDTH = 4,
    parameter int OP_WIDTH   = 2,
    parameter int FILTER_W   = 24,
    parameter int SPIKE_W    = 5,
    parameter int PKT_W      = 39,
    parameter int DEPTH      = 4,
    parameter int SRC_ADDR   = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    noc_packet_encoder_if.slave bus,
    output logic             idle,
    output logic [CNT_W-1:0] tx_count,
    output logic             err_illegal_op
`ifdef SPIKE_ZERO_SUPPRESS_EN
    ,
    output logic [CNT_W-1:0] suppress_count
`endif
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    // First payload bit, just above dest, src and op.
    localparam int PB    = 2 * ADDR_WIDTH + OP_WIDTH;

    logic [PKT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             ready_en;
    logic             full;
    logic             empty;
    logic             accept;
    logic             pop;
    logic             push;
    logic             illegal;
    logic             suppress;
    logic [PKT_W-1:0] packed_pkt;

    assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // ready_en keeps cmd_ready low until the first edge after reset release.
    assign bus.cmd_ready = ready_en && !full;
    assign bus.pkt_valid = !empty;
    assign bus.pkt_data  = empty ? '0 : mem[rd_ptr[IDX_W-1:0]];
    assign idle          = empty;

    assign accept  = bus.cmd_valid && bus.cmd_ready;
    assign pop     = bus.pkt_valid && bus.pkt_ready;
    assign illegal = (bus.cmd_op == OP_WIDTH'(3));
`ifdef SPIKE_ZERO_SUPPRESS_EN
    assign suppress = (bus.cmd_op == OP_WIDTH'(1)) && (bus.cmd_spike == '0);
`else
    assign suppress = 1'b0;
`endif
    assign push = accept && !illegal && !suppress;

    // Build the packet for the command currently presented; unused fields are zero.
    always_comb begin
        packed_pkt = '0;
        packed_pkt[ADDR_WIDTH-1:0]            = bus.cmd_dest;
        packed_pkt[2*ADDR_WIDTH-1:ADDR_WIDTH] = ADDR_WIDTH'(SRC_ADDR);
        packed_pkt[PB-1:2*ADDR_WIDTH]         = bus.cmd_op;
        if (bus.cmd_op == OP_WIDTH'(0)) begin
            packed_pkt[PB+FILTER_W-1:PB]                  = bus.cmd_filter;
            packed_pkt[PB+FILTER_W+SPIKE_W-1:PB+FILTER_W] = bus.cmd_spike;
        end else if (bus.cmd_op == OP_WIDTH'(1)) begin
            packed_pkt[PB+SPIKE_W-1:PB] = bus.cmd_spike;
        end else if (bus.cmd_op == OP_WIDTH'(2)) begin
            packed_pkt[PB+FILTER_W-1:PB] = bus.cmd_filter;
        end
    end

    // FIFO pointers and the post-reset ready enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // FIFO storage; contents are only visible through a valid head pointer.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[IDX_W-1:0]] <= packed_pkt;
    end

    // Transmit counter and sticky illegal-op flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_count       <= '0;
            err_illegal_op <= 1'b0;
        end else begin
            if (pop)               tx_count       <= tx_count + CNT_W'(1);
            if (accept && illegal) err_illegal_op <= 1'b1;
        end
    end

`ifdef SPIKE_ZERO_SUPPRESS_EN
    // Count op 1 commands dropped for carrying an empty spike frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) suppress_count <= '0;
        else if (accept && suppress) suppress_count <= suppress_count + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_noc_packet_encoder.sv
// tb_noc_packet_encoder: directed and randomized stimulus for
// noc_packet_encoder (SRC_ADDR = 3, DEPTH = 4), checked against a queue-based
// reference model. Honours SPIKE_ZERO_SUPPRESS_EN when defined.
module tb_noc_packet_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam logic [3:0] SRC = 4'd3;

    logic clk;
    logic rst_n;
    logic idle;
    logic [CNT_W-1:0] tx_count;
    logic err_illegal_op;
    logic [CNT_W-1:0] sup_count;

    noc_packet_encoder_if #(.ADDR_WIDTH(4), .OP_WIDTH(2), .FILTER_W(24), .SPIKE_W(5), .PKT_W(39)) bus ();

    noc_packet_encoder #(.DEPTH(DEPTH), .SRC_ADDR(3), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.slave),
        .idle           (idle),
        .tx_count       (tx_count),
        .err_illegal_op (err_illegal_op)
`ifdef SPIKE_ZERO_SUPPRESS_EN
        ,
        .suppress_count (sup_count)
`endif
    );

`ifndef SPIKE_ZERO_SUPPRESS_EN
    assign sup_count = '0;
`endif

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [38:0] exp_q[$];
    int          exp_tx  = 0;
    int          exp_sup = 0;
    bit          exp_err = 0;
    bit          armed   = 0;

    function automatic logic [38:0] model_pkt(input logic [1:0] op, input logic [3:0] dest,
                                              input logic [23:0] filt, input logic [4:0] spk);
        logic [28:0] payload;
        case (op)
            2'd0:    payload = {spk, filt};
            2'd1:    payload = {24'd0, spk};
            default: payload = {5'd0, filt};
        endcase
        return {payload, op, SRC, dest};
    endfunction

    function automatic bit model_drops(input logic [1:0] op, input logic [4:0] spk);
`ifdef SPIKE_ZERO_SUPPRESS_EN
        return (op == 2'd3) || (op == 2'd1 && spk == 5'd0);
`else
        return (op == 2'd3);
`endif
    endfunction

    // Monitor: compare outputs with the model, then advance it across the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_tx  = 0;
            exp_sup = 0;
            exp_err = 0;
            armed   = 0;
            check("rst_pkt_valid", bus.pkt_valid, 0);
            check("rst_cmd_ready", bus.cmd_ready, 0);
        end else begin
            bit can_push;
            check("pkt_valid", bus.pkt_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) check("pkt_data", bus.pkt_data, exp_q[0]);
            else                   check("pkt_data_empty", bus.pkt_data, 0);
            check("idle", idle, exp_q.size() == 0);
            can_push = armed && (exp_q.size() < DEPTH);
            check("cmd_ready", bus.cmd_ready, can_push);
            check("tx_count", tx_count, CNT_W'(exp_tx));
            check("err_illegal_op", err_illegal_op, exp_err);
`ifdef SPIKE_ZERO_SUPPRESS_EN
            check("suppress_count", sup_count, CNT_W'(exp_sup));
`endif
            if (exp_q.size() != 0 && bus.pkt_ready) begin
                void'(exp_q.pop_front());
                exp_tx++;
            end
            if (bus.cmd_valid && can_push) begin
                if (bus.cmd_op == 2'd3) exp_err = 1;
                else if (model_drops(bus.cmd_op, bus.cmd_spike)) exp_sup++;
                if (!model_drops(bus.cmd_op, bus.cmd_spike))
                    exp_q.push_back(model_pkt(bus.cmd_op, bus.cmd_dest, bus.cmd_filter, bus.cmd_spike));
            end
            armed = 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic set_cmd(input logic [1:0] op, input logic [3:0] dest,
                           input logic [23:0] filt, input logic [4:0] spk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_dest   = dest;
        bus.cmd_filter = filt;
        bus.cmd_spike  = spk;
    endtask

    // Present one command and hold it until the handshake edge has passed.
    task automatic send_cmd(input logic [1:0] op, input logic [3:0] dest,
                            input logic [23:0] filt, input logic [4:0] spk);
        bit done = 0;
        set_cmd(op, dest, filt, spk);
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) done = 1;
            tick();
        end
        bus.cmd_valid = 1'b0;
        if (!done) check("cmd_timeout", 0, 1);
    endtask

    task automatic drain();
        bus.pkt_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) check("drain_timeout", 0, 1);
    endtask

    // ---------------- stimulus ----------------
    logic [38:0] cap;
    logic [38:0] first_pkt;

    initial begin
        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = '0;
        bus.cmd_dest   = '0;
        bus.cmd_filter = '0;
        bus.cmd_spike  = '0;
        bus.pkt_ready  = 1'b1;

        #2;
        check("reset_pkt_valid", bus.pkt_valid, 0);
        check("reset_pkt_data", bus.pkt_data, 0);
        check("reset_idle", idle, 1);
        check("reset_tx_count", tx_count, 0);
        check("reset_err", err_illegal_op, 0);
        check("reset_cmd_ready", bus.cmd_ready, 0);
        apply_reset();

        // Op 0 encode with one-cycle latency.
        send_cmd(2'd0, 4'd5, 24'hABCDEF, 5'b10110);
        @(negedge clk);
        check("op0_valid", bus.pkt_valid, 1);
        check("op0_data", bus.pkt_data, {5'b10110, 24'hABCDEF, 2'd0, 4'd3, 4'd5});
        tick();
        @(negedge clk);
        check("op0_tx_count", tx_count, 1);
        check("op0_idle", idle, 1);
        tick();

        // Op 1 and op 2 encode (hold the packet to inspect fields).
        bus.pkt_ready = 1'b0;
        send_cmd(2'd1, 4'd2, 24'hFFFFFF, 5'h1F);
        @(negedge clk);
        cap = bus.pkt_data;
        check("op1_spike", cap[14:10], 5'h1F);
        check("op1_upper", cap[38:15], 0);
        check("op1_op", cap[9:8], 2'd1);
        drain();
        bus.pkt_ready = 1'b0;
        send_cmd(2'd2, 4'd7, 24'h123456, 5'h15);
        @(negedge clk);
        cap = bus.pkt_data;
        check("op2_filter", cap[33:10], 24'h123456);
        check("op2_upper", cap[38:34], 0);
        check("op2_op", cap[9:8], 2'd2);
        drain();

        // Backpressure: fill to DEPTH, the fifth command must wait.
        bus.pkt_ready = 1'b0;
        first_pkt = model_pkt(2'd0, 4'd1, 24'h000001, 5'd1);
        for (int i = 1; i <= 4; i++) send_cmd(2'd0, 4'(i), 24'(i), 5'(i));
        set_cmd(2'd0, 4'd5, 24'd5, 5'd5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("full_cmd_ready", bus.cmd_ready, 0);
            check("full_hold", bus.pkt_data, first_pkt);
            tick();
        end
        bus.pkt_ready = 1'b1;
        @(negedge clk);
        check("full_before_pop", bus.cmd_ready, 0);
        tick();
        @(negedge clk);
        check("ready_after_pop", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        drain();
        tick();

        // Simultaneous push and pop at occupancy 2 for 20 edges.
        apply_reset();
        bus.pkt_ready = 1'b0;
        send_cmd(2'd0, 4'd9, 24'h0A0A0A, 5'd3);
        send_cmd(2'd2, 4'd8, 24'h0B0B0B, 5'd4);
        bus.pkt_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_cmd(2'($urandom_range(0, 2)), 4'($urandom), 24'($urandom), 5'($urandom_range(1, 31)));
            @(negedge clk);
            check("steady_ready", bus.cmd_ready, 1);
            check("steady_valid", bus.pkt_valid, 1);
            tick();
        end
        bus.cmd_valid = 1'b0;
        bus.pkt_ready = 1'b0;
        @(negedge clk);
        check("steady_tx_count", tx_count, 20);
        tick();
        drain();

        // Illegal op: handshake completes, nothing queued, flag sticky.
        send_cmd(2'd3, 4'd4, 24'h111111, 5'd2);
        @(negedge clk);
        check("illegal_err", err_illegal_op, 1);
        check("illegal_no_pkt", bus.pkt_valid, 0);
        tick();
        send_cmd(2'd0, 4'd4, 24'h222222, 5'd6);
        @(negedge clk);
        check("illegal_sticky", err_illegal_op, 1);
        tick();
        drain();

        // Reset mid-stream with three queued packets.
        bus.pkt_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_cmd(2'd0, 4'(i), 24'(i + 16), 5'(i + 1));
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", bus.pkt_valid, 0);
        check("midrst_tx", tx_count, 0);
        check("midrst_err", err_illegal_op, 0);
        check("midrst_idle", idle, 1);
        check("midrst_data", bus.pkt_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Op 1 with empty spike frame.
        bus.pkt_ready = 1'b1;
        send_cmd(2'd1, 4'd6, 24'h333333, 5'd0);
        @(negedge clk);
`ifdef SPIKE_ZERO_SUPPRESS_EN
        check("zs_op1_dropped", bus.pkt_valid, 0);
        check("zs_count", sup_count, 1);
`else
        check("zs_op1_sent", bus.pkt_valid, 1);
`endif
        tick();
        drain();
        send_cmd(2'd0, 4'd6, 24'h444444, 5'd0);
        @(negedge clk);
        check("zs_op0_sent", bus.pkt_valid, 1);
        tick();
        drain();

        // Randomized traffic, including illegal ops and zero spikes.
        for (int i = 0; i < 400; i++) begin
            bus.cmd_valid  = ($urandom_range(0, 3) != 0);
            bus.cmd_op     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            bus.cmd_dest   = 4'($urandom);
            bus.cmd_filter = 24'($urandom);
            bus.cmd_spike  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            bus.pkt_ready  = ($urandom_range(0, 2) != 0);
            tick();
        end
        bus.cmd_valid = 1'b0;
        drain();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/noc_packet_encoder.md
Name: noc_packet_encoder

Overview:
- Transmit-side counterpart of the PE packet decoder. It accepts frame-level commands from the memory controller or a PE, packs them into 39-bit NoC packets, and buffers them in a small FIFO.
- Packets leave on a valid/ready channel to the NoC router injection port.
- Field layout matches the PE decoder exactly, so a decoder at the destination recovers the same op, addresses, filter frame and spike frame.

Parameters:
- ADDR_WIDTH, 4, width of source and destination address fields
- OP_WIDTH, 2, width of operation field
- FILTER_W, 24, filter frame width
- SPIKE_W, 5, spike frame width
- PKT_W, 39, packet width; must equal 2*ADDR_WIDTH+OP_WIDTH+FILTER_W+SPIKE_W
- DEPTH, 4, FIFO entries; power of 2, at least 2
- SRC_ADDR, 0, this node's address, placed in the source field
- CNT_W, 16, width of the transmitted-packet counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when high together with cmd_valid
- cmd_op  in  OP_WIDTH  0 = filter+spike (MEM->PE), 1 = spike only (MEM->PE), 2 = filter only (PE->PE), 3 = illegal
- cmd_dest  in  ADDR_WIDTH  destination node address
- cmd_filter  in  FILTER_W  filter frame
- cmd_spike  in  SPIKE_W  spike frame
- pkt_valid  out  1  packet available
- pkt_ready  in  1  NoC accepts the packet
- pkt_data  out  PKT_W  packed packet
- idle  out  1  FIFO empty
- tx_count  out  CNT_W  number of packets handed off to the NoC
- err_illegal_op  out  1  sticky flag: an op 3 command was received

Behaviour:
- Reset (rst_n low, asynchronous):
  - read/write pointers cleared; pkt_valid=0, pkt_data=0, idle=1, tx_count=0, err_illegal_op=0.
  - Reset asserted mid-transfer discards all queued packets with no partial output.
  - cmd_ready=0 while rst_n is low; it reflects not-full from the first edge after release.
- Packing is computed at enqueue time and stored per FIFO entry:
  - [3:0] = cmd_dest; [7:4] = SRC_ADDR; [9:8] = cmd_op (all ops).
  - op 0: [33:10] = filter, [38:34] = spike.
  - op 1: [14:10] = spike, [38:15] = 0.
  - op 2: [33:10] = filter, [38:34] = 0.
  - Unused command fields are ignored.
- Enqueue:
  - Occurs on a rising edge with cmd_valid && cmd_ready.
  - cmd_ready = !full. This is a registered-pointer comparison; there is no combinational path from pkt_ready.
- Illegal op 3:
  - The command is accepted (handshake completes) but not enqueued.
  - err_illegal_op is set on that edge and stays set until reset.
- Dequeue:
  - Occurs on a rising edge with pkt_valid && pkt_ready.
  - pkt_valid = !empty; pkt_data = head entry.
  - pkt_data and pkt_valid hold stable while pkt_valid && !pkt_ready.
- Latency: a command accepted at edge N gives pkt_valid=1 with correct pkt_data in the cycle after edge N. There is no same-cycle bypass.
- Simultaneous push and pop:
  - Not full and not empty: both occur and occupancy is unchanged.
  - Full: cmd_ready=0, so only the pop occurs; cmd_ready rises the next cycle.
  - Empty: only the push occurs.
- Pointers are log2(DEPTH)+1 bits with a wrap bit:
  - full when the low bits are equal and the wrap bits differ;
  - empty when the pointers are fully equal;
  - pointers wrap modulo 2*DEPTH.
- tx_count increments by 1 on each dequeue handshake and wraps from all-ones to 0.
- idle = empty.

Optional Feature:
- Macro SPIKE_ZERO_SUPPRESS_EN.
- Defined:
  - An op 1 command with cmd_spike == 0 is accepted but not enqueued, and no packet is sent.
  - Output port suppress_count (CNT_W, reset 0, wraps) increments on each suppressed command.
  - Op 0 packets are never suppressed.
- Undefined: all op 1 commands are enqueued normally, and the suppress_count port does not exist.

Test Plan:
- Op 0 encode: SRC_ADDR=3; cmd dest=5, filter=24'hABCDEF, spike=5'b10110, pkt_ready=1 -> one cycle later pkt_data={5'b10110, 24'hABCDEF, 2'd0, 4'd3, 4'd5}; tx_count=1; idle=1 after the dequeue.
- Op 1 and op 2 encode: op 1 spike=5'h1F, dest=2 -> pkt_data[14:10]=5'h1F, [38:15]=0, [9:8]=1. Op 2 filter=24'h123456 -> [33:10]=24'h123456, [38:34]=0, [9:8]=2.
- Backpressure/full: pkt_ready=0, push 5 commands with DEPTH=4 -> first 4 accepted, cmd_ready=0 on the 5th. pkt_data holds the first packet unchanged for 10 cycles. Raise pkt_ready -> packets appear in order 1..4, and the 5th is accepted the cycle after the first pop.
- Simultaneous push and pop at occupancy 2 over 20 cycles -> occupancy stays 2, no loss or duplication, pointer wrap exercised, tx_count=20.
- Illegal op and reset: op 3 command -> cmd_ready handshake completes, no packet, err_illegal_op=1 and stays 1. Assert rst_n low mid-stream with 3 queued -> pkt_valid=0, tx_count=0, err_illegal_op=0 immediately.
- SPIKE_ZERO_SUPPRESS_EN: op 1 with spike=0 -> no packet and suppress_count=1; op 0 with spike=0 -> packet sent. Without the macro, op 1 with spike=0 -> packet sent.
